// File: rtl/sqrt_arbiter_if.sv
// Bundle of the sqrt_arbiter requester, core and result channels.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface sqrt_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
);
  // Requester side
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*WIDTH-1:0] i_req_rad;
  logic [N_REQ-1:0]       o_req_ready;
  // Core side
  logic                   o_sq_start;
  logic [WIDTH-1:0]       o_sq_rad;
  logic                   i_sq_busy;
  logic                   i_sq_valid;
  logic [WIDTH-1:0]       i_sq_root;
  logic [WIDTH-1:0]       i_sq_rem;
  // Result side
  logic                   o_res_valid;
  logic                   i_res_ready;
  logic [ID_W-1:0]        o_res_id;
  logic [WIDTH-1:0]       o_res_root;
  logic [WIDTH-1:0]       o_res_rem;
  logic                   o_res_err;
  logic [7:0]             o_timeout_cnt;
  // Debug view of the sequencer state
  logic [1:0]             o_dbg_state;

  modport slave (
    input  i_req_valid, i_req_rad, i_sq_busy, i_sq_valid, i_sq_root, i_sq_rem, i_res_ready,
    output o_req_ready, o_sq_start, o_sq_rad, o_res_valid, o_res_id, o_res_root, o_res_rem,
           o_res_err, o_timeout_cnt, o_dbg_state
  );

  modport master (
    output i_req_valid, i_req_rad, i_sq_busy, i_sq_valid, i_sq_root, i_sq_rem, i_res_ready,
    input  o_req_ready, o_sq_start, o_sq_rad, o_res_valid, o_res_id, o_res_root, o_res_rem,
           o_res_err, o_timeout_cnt, o_dbg_state
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that shares one square_root core among N_REQ requesters,
// returns ID-tagged results and issues an error result if the core hangs.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are
// both high. A source holds valid and its payload stable until ready; a request
// valid may drop before being granted. Ready never waits on anything but the
// arbiter's own state and the core busy flag.
module sqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sqrt_arbiter_if.slave  bus
);

  // The watchdog only needs to count 0..TIMEOUT-1
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             res_valid_q, res_valid_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [7:0]       tcnt_q, tcnt_d;

  logic             any_valid;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    idx;
  logic [N_REQ-1:0] grant;

  // Round-robin search from ptr; scanning offsets downward leaves the nearest valid as winner.
  // Ready is held low during reset so every output reads 0 while reset is asserted.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    grant     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (bus.i_req_valid[idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[ID_W-1:0];
      end
    end
    if (state_q == S_IDLE && any_valid && !bus.i_sq_busy && i_rst_n) grant[winner] = 1'b1;
  end

  // Sequencer next-state: IDLE -> START -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    rad_d       = rad_q;
    root_d      = root_q;
    rem_d       = rem_q;
    err_d       = err_q;
    start_d     = 1'b0;
    res_valid_d = res_valid_q;
    wd_d        = wd_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          rad_d   = bus.i_req_rad[int'(winner)*WIDTH +: WIDTH];
          id_d    = winner;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A finished core beats the watchdog when both happen in the same cycle
        if (bus.i_sq_valid && !bus.i_sq_busy) begin
          root_d      = bus.i_sq_root;
          rem_d       = bus.i_sq_rem;
          err_d       = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          root_d      = '0;
          rem_d       = '0;
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d     = S_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RESP: begin
        if (bus.i_res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      rad_q       <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      wd_q        <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      rad_q       <= rad_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      wd_q        <= wd_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.o_req_ready   = grant;
  assign bus.o_sq_start    = start_q;
  assign bus.o_sq_rad      = rad_q;
  assign bus.o_res_valid   = res_valid_q;
  assign bus.o_res_id      = id_q;
  assign bus.o_res_root    = root_q;
  assign bus.o_res_rem     = rem_q;
  assign bus.o_res_err     = err_q;
  assign bus.o_timeout_cnt = tcnt_q;
  assign bus.o_dbg_state   = state_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Testbench for sqrt_arbiter with a cycle-level model of the square_root core
// (ITER busy cycles, sticky valid) and a reference model for results and RR order.
module tb_sqrt_arbiter;
  localparam int N_REQ   = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int ITER    = 16;
  localparam int RW      = 1 + ID_W + 2*WIDTH;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqrt_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Stimulus state
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       sticky    = '0;
  logic [N_REQ*WIDTH-1:0] req_rad   = '0;
  logic                   res_ready = 1'b0;
  // Core model state (the core has no reset)
  logic                   core_busy  = 1'b0;
  logic                   core_valid = 1'b0;
  logic [WIDTH-1:0]       core_root  = '0;
  logic [WIDTH-1:0]       core_rem   = '0;
  int                     core_cnt   = 0;
  logic                   core_hang  = 1'b0;

  assign bus.i_req_valid = req_valid;
  assign bus.i_req_rad   = req_rad;
  assign bus.i_res_ready = res_ready;
  assign bus.i_sq_busy   = core_busy;
  assign bus.i_sq_valid  = core_valid;
  assign bus.i_sq_root   = core_root;
  assign bus.i_sq_rem    = core_rem;

  // Scoreboard
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int grant_q[$];

  function automatic logic [RW-1:0] pack(input logic err, input int id,
                                         input logic [WIDTH-1:0] root, input logic [WIDTH-1:0] rem);
    return {err, ID_W'(id), root, rem};
  endfunction

  // Reference: largest r with r*r <= x, built greedily bit by bit in 64-bit arithmetic
  function automatic logic [RW-1:0] ref_result(input int id, input logic [WIDTH-1:0] x);
    longint unsigned r, t, xv;
    r = 0;
    xv = longint'(x);
    for (int b = 15; b >= 0; b--) begin
      t = r + (64'd1 << b);
      if (t * t <= xv) r = t;
    end
    return pack(1'b0, id, WIDTH'(r), WIDTH'(xv - r * r));
  endfunction

  // Core arithmetic: digit-by-digit integer square root
  function automatic void core_sqrt(input logic [31:0] x, output logic [31:0] root, output logic [31:0] rem);
    logic [31:0] op, res, one;
    op = x;
    res = 0;
    one = 32'h4000_0000;
    while (one > op) one = one >> 2;
    while (one != 0) begin
      if (op >= res + one) begin
        op  = op - (res + one);
        res = (res >> 1) + one;
      end else begin
        res = res >> 1;
      end
      one = one >> 2;
    end
    root = res;
    rem  = op;
  endfunction

  // Driver: advance one clock; records handshakes seen in the cycle being left and steps the core model
  task automatic tick();
    logic [N_REQ-1:0] hs;
    logic             st;
    logic [WIDTH-1:0] rad_s;
    #1;
    hs    = req_valid & bus.o_req_ready;
    st    = bus.o_sq_start;
    rad_s = bus.o_sq_rad;
    if (bus.o_res_valid && res_ready)
      got_q.push_back({bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem});
    for (int k = 0; k < N_REQ; k++) if (hs[k]) grant_q.push_back(k);
    @(posedge clk);
    #1;
    cyc++;
    req_valid = req_valid & ~(hs & ~sticky);
    if (st) begin
      core_valid = 1'b0;
      if (core_hang) begin
        core_busy = 1'b0;
      end else begin
        core_busy = 1'b1;
        core_cnt  = ITER;
        core_sqrt(rad_s, core_root, core_rem);
      end
    end else if (core_busy) begin
      if (core_cnt == 1) begin
        core_busy  = 1'b0;
        core_valid = 1'b1;
      end else begin
        core_cnt--;
      end
    end
  endtask

  task automatic set_req(input int k, input logic [WIDTH-1:0] rad);
    req_rad[k*WIDTH +: WIDTH] = rad;
    req_valid[k] = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    sticky = '0;
    res_ready = 1'b0;
    core_hang = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    got_q.delete();
    grant_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0010;
    tick();
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", bus.o_req_ready); end
    checks++;
    if ({bus.o_sq_start, bus.o_res_valid, bus.o_res_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: start/valid/err got %b want 000", {bus.o_sq_start, bus.o_res_valid, bus.o_res_err});
    end
    checks++;
    if ({bus.o_sq_rad, bus.o_res_root, bus.o_res_rem, bus.o_res_id} !== '0) begin
      failures++; $display("FAIL reset_data: rad=%h root=%h rem=%h id=%0d want all 0", bus.o_sq_rad, bus.o_res_root, bus.o_res_rem, bus.o_res_id);
    end
    checks++;
    if (bus.o_timeout_cnt !== 8'd0 || bus.o_dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_cnt_state: tcnt=%0d state=%0d want 0 0", bus.o_timeout_cnt, bus.o_dbg_state);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int base, start_cnt, start_cyc, res_cyc;
    bit extra_ready;
    logic [RW-1:0] g;
    set_req(1, 32'd150);
    res_ready = 1'b1;
    base = cyc;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0010) begin failures++; $display("FAIL single_grant: ready got %b want 0010", bus.o_req_ready); end
    start_cnt = 0; start_cyc = -1; res_cyc = -1; extra_ready = 0;
    for (int n = 0; n < 40 && res_cyc < 0; n++) begin
      tick();
      #1;
      if (bus.o_sq_start) begin start_cnt++; start_cyc = cyc - base; end
      if (bus.o_req_ready != '0) extra_ready = 1;
      if (bus.o_res_valid) res_cyc = cyc - base;
    end
    checks++;
    if (start_cnt != 1 || start_cyc != 1) begin failures++; $display("FAIL single_start: pulses=%0d at cycle %0d want 1 at 1", start_cnt, start_cyc); end
    checks++;
    if (res_cyc != 19) begin failures++; $display("FAIL single_latency: res_valid at cycle %0d want 19", res_cyc); end
    checks++;
    if (extra_ready) begin failures++; $display("FAIL single_ready_once: ready seen after cycle 0, want only cycle 0"); end
    checks++;
    if ({bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem} !== pack(1'b0, 1, 32'd12, 32'd6)) begin
      failures++; $display("FAIL single_result: err=%b id=%0d root=%0d rem=%0d want 0 1 12 6", bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem);
    end
    tick();
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL single_handshake: results=%0d want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== pack(1'b0, 1, 32'd12, 32'd6)) begin failures++; $display("FAIL single_handshake: got %h want %h", g, pack(1'b0, 1, 32'd12, 32'd6)); end
    end
    #1;
    checks++;
    if (bus.o_res_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop: res_valid got %b want 0", bus.o_res_valid); end
  endtask

  task automatic test_all_four();
    bit ok;
    logic [RW-1:0] g, e;
    apply_reset();
    res_ready = 1'b1;
    set_req(0, 32'd0);
    set_req(1, 32'd1);
    set_req(2, 32'd144);
    set_req(3, 32'hFFFF_FFFF);
    exp_q.push_back(pack(1'b0, 0, 32'd0, 32'd0));
    exp_q.push_back(pack(1'b0, 1, 32'd1, 32'd0));
    exp_q.push_back(pack(1'b0, 2, 32'd12, 32'd0));
    exp_q.push_back(pack(1'b0, 3, 32'd65535, 32'd131070));
    wait_results(4, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL all_four_count: results=%0d want 4", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL all_four_result: got %h want %h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_fairness();
    bit ok;
    logic [RW-1:0] g, e;
    got_q.delete();
    sticky[0] = 1'b1;
    set_req(0, 32'd50);
    set_req(3, 32'd99);
    exp_q.push_back(pack(1'b0, 0, 32'd7, 32'd1));
    exp_q.push_back(pack(1'b0, 3, 32'd9, 32'd18));
    exp_q.push_back(pack(1'b0, 0, 32'd7, 32'd1));
    wait_results(3, 200, ok);
    sticky = '0;
    req_valid[0] = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL fair_count: results=%0d want 3", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL fair_order: got %h want %h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_pressure();
    int n;
    bit unstable, ready_seen, ok;
    logic [RW-1:0] snap, g;
    got_q.delete();
    res_ready = 1'b0;
    set_req(1, 32'd1000);
    n = 0;
    while (!bus.o_res_valid && n < 50) begin tick(); #1; n++; end
    checks++;
    if (!bus.o_res_valid) begin failures++; $display("FAIL bp_reach_resp: res_valid got 0 want 1"); end
    set_req(2, 32'd2000);
    snap = {bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem};
    unstable = 0; ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if ({bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem} !== snap || !bus.o_res_valid) unstable = 1;
      if (bus.o_req_ready != '0) ready_seen = 1;
    end
    checks++;
    if (unstable || snap !== pack(1'b0, 1, 32'd31, 32'd39)) begin
      failures++; $display("FAIL bp_stable: snapshot %h unstable=%0d want %h held", snap, unstable, pack(1'b0, 1, 32'd31, 32'd39));
    end
    res_ready = 1'b1;
    #1;
    if (bus.o_req_ready != '0) ready_seen = 1;
    checks++;
    if (ready_seen) begin failures++; $display("FAIL bp_no_grant: ready seen during RESP, want none"); end
    tick();
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant_after: ready got %b want 0100", bus.o_req_ready); end
    wait_results(2, 60, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_second: results=%0d want 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      g = got_q.pop_front();
      if (g !== pack(1'b0, 2, 32'd44, 32'd64)) begin failures++; $display("FAIL bp_second: got %h want %h", g, pack(1'b0, 2, 32'd44, 32'd64)); end
    end
  endtask

  task automatic test_timeout();
    int base, n, res_cyc;
    bit ok;
    logic [RW-1:0] g;
    got_q.delete();
    core_hang = 1'b1;
    res_ready = 1'b1;
    set_req(3, 32'd400);
    base = cyc;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b1000) begin failures++; $display("FAIL to_grant: ready got %b want 1000", bus.o_req_ready); end
    n = 0; res_cyc = -1;
    while (res_cyc < 0 && n < 150) begin
      tick(); #1; n++;
      if (bus.o_res_valid) res_cyc = cyc - base;
    end
    checks++;
    if (res_cyc != TIMEOUT + 2) begin failures++; $display("FAIL to_latency: res_valid at cycle %0d want %0d", res_cyc, TIMEOUT + 2); end
    checks++;
    if ({bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem} !== pack(1'b1, 3, 32'd0, 32'd0)) begin
      failures++; $display("FAIL to_result: err=%b id=%0d root=%0d rem=%0d want 1 3 0 0", bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem);
    end
    checks++;
    if (bus.o_timeout_cnt !== 8'd1) begin failures++; $display("FAIL to_count: tcnt got %0d want 1", bus.o_timeout_cnt); end
    tick();
    core_hang = 1'b0;
    got_q.delete();
    set_req(0, 32'd150);
    base = cyc;
    n = 0; res_cyc = -1;
    while (res_cyc < 0 && n < 60) begin
      tick(); #1; n++;
      if (bus.o_res_valid) res_cyc = cyc - base;
    end
    checks++;
    if (res_cyc != 19) begin failures++; $display("FAIL to_recover_latency: res_valid at cycle %0d want 19", res_cyc); end
    wait_results(1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL to_recover: no result");
    end else begin
      g = got_q.pop_front();
      if (g !== pack(1'b0, 0, 32'd12, 32'd6) || bus.o_timeout_cnt !== 8'd1) begin
        failures++; $display("FAIL to_recover: got %h tcnt=%0d want %h tcnt=1", g, bus.o_timeout_cnt, pack(1'b0, 0, 32'd12, 32'd6));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit ready_seen, ok;
    logic [RW-1:0] g;
    got_q.delete();
    res_ready = 1'b1;
    set_req(1, 32'd625);
    repeat (5) tick();
    set_req(2, 32'd90);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_req_ready !== '0 || bus.o_sq_start !== 1'b0 || bus.o_sq_rad !== '0 || bus.o_res_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ctrl: ready=%b start=%b rad=%h valid=%b want all 0", bus.o_req_ready, bus.o_sq_start, bus.o_sq_rad, bus.o_res_valid);
    end
    checks++;
    if ({bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem} !== '0 || bus.o_timeout_cnt !== 8'd0 || bus.o_dbg_state !== 2'd0) begin
      failures++; $display("FAIL mid_reset_data: res=%h tcnt=%0d state=%0d want 0 0 0",
                           {bus.o_res_err, bus.o_res_id, bus.o_res_root, bus.o_res_rem}, bus.o_timeout_cnt, bus.o_dbg_state);
    end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    ready_seen = 0;
    n = 0;
    while (core_busy && n < 40) begin
      #1;
      if (bus.o_req_ready != '0) ready_seen = 1;
      tick();
      n++;
    end
    checks++;
    if (ready_seen || core_busy) begin failures++; $display("FAIL mid_busy_hold: ready_seen=%0d busy=%b want 0 0", ready_seen, core_busy); end
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin failures++; $display("FAIL mid_grant: ready got %b want 0100", bus.o_req_ready); end
    wait_results(1, 60, ok);
    repeat (3) tick();
    checks++;
    if (!ok || got_q.size() != 1) begin
      failures++; $display("FAIL mid_result_count: results=%0d want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== pack(1'b0, 2, 32'd9, 32'd9)) begin failures++; $display("FAIL mid_result: got %h want %h", g, pack(1'b0, 2, 32'd9, 32'd9)); end
    end
  endtask

  task automatic test_random();
    int mptr, done, k, win;
    logic [WIDTH-1:0] r;
    logic [RW-1:0] g, e;
    logic [N_REQ-1:0] oh;
    apply_reset();
    mptr = 0;
    done = 0;
    for (int c = 0; c < 4000 && done < 30; c++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!req_valid[j] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0:       r = '0;
            1:       r = 32'd1;
            2:       r = '1;
            3:       r = WIDTH'($urandom_range(0, 1000));
            default: r = $urandom;
          endcase
          set_req(j, r);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.o_req_ready != '0) begin
        win = -1;
        for (int i = 0; i < N_REQ; i++) begin
          k = (mptr + i) % N_REQ;
          if (win < 0 && req_valid[k]) win = k;
        end
        checks++;
        if (win < 0) begin
          failures++; $display("FAIL rnd_grant: ready %b with no valid request", bus.o_req_ready);
        end else begin
          oh = '0;
          oh[win] = 1'b1;
          if (bus.o_req_ready !== oh) begin failures++; $display("FAIL rnd_grant: ready got %b want %b", bus.o_req_ready, oh); end
          checks++;
          if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_outstanding: %0d in flight at grant, want 0", exp_q.size()); end
          exp_q.push_back(ref_result(win, req_rad[win*WIDTH +: WIDTH]));
        end
      end
      tick();
      if (got_q.size() != 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_result: unexpected result %h", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin failures++; $display("FAIL rnd_result: got %h want %h", g, e); end
          mptr = (int'(e[RW-2 -: ID_W]) + 1) % N_REQ;
        end
        done++;
      end
    end
    checks++;
    if (done < 30) begin failures++; $display("FAIL rnd_progress: results=%0d want 30", done); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_back_pressure();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `square_root` core among N_REQ requesters, for example per-instrument volatility and risk engines.
- Accepts radicands over per-requester valid/ready handshakes and drives the core's start/radicand inputs.
- Captures root and remainder, and returns them tagged with the requester ID over a backpressured result channel.
- Includes a watchdog that flags a core that never completes.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, radicand/root/remainder width; must match the attached core.
- ID_W, $clog2(N_REQ), width of the requester ID.
- TIMEOUT, 64, maximum cycles allowed in WAIT before an error result is issued (must exceed core ITER+1).

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  N_REQ  per-requester request valid.
- i_req_rad  input  N_REQ*WIDTH  radicands; requester k occupies bits [k*WIDTH +: WIDTH].
- o_req_ready  output  N_REQ  per-requester accept; at most one bit high.
- o_sq_start  output  1  start pulse to core.
- o_sq_rad  output  WIDTH  radicand to core.
- i_sq_busy  input  1  core busy.
- i_sq_valid  input  1  core result valid (sticky until next start).
- i_sq_root  input  WIDTH  core root.
- i_sq_rem  input  WIDTH  core remainder.
- o_res_valid  output  1  result valid.
- i_res_ready  input  1  downstream accepts result.
- o_res_id  output  ID_W  requester index of the result.
- o_res_root  output  WIDTH  root.
- o_res_rem  output  WIDTH  remainder.
- o_res_err  output  1  result produced by timeout; root and remainder are 0.
- o_timeout_cnt  output  8  saturating count of timeouts since reset.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - State goes to IDLE; the RR pointer goes to 0.
  - All outputs are 0, including o_sq_rad, result registers and o_timeout_cnt.
- Reset mid-operation abandons the request silently. No result is issued.
- State machine: IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. The winner is the first k with i_req_valid[k]=1, searching k = ptr, ptr+1, ... mod N_REQ.
  - o_req_ready[winner]=1 only when some valid is high and i_sq_busy=0. This covers a core still running after our reset, since the core has no reset.
  - On handshake: latch the radicand into the o_sq_rad register and the winner into the ID register, then go to START.
- START:
  - o_sq_start=1 for exactly one cycle; o_sq_rad is stable.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - o_sq_rad is held stable.
  - When i_sq_valid=1 && i_sq_busy=0: capture i_sq_root/i_sq_rem, set o_res_err=0, go to RESP.
  - Else increment the watchdog. When it reaches TIMEOUT-1: set o_res_err=1, root=rem=0, increment o_timeout_cnt (saturating at 255), go to RESP.
  - A valid result and the watchdog limit in the same cycle: the valid result wins.
- RESP:
  - o_res_valid=1; id/root/rem/err are held stable until i_res_ready=1.
  - On handshake: ptr <= (id+1) mod N_REQ, o_res_valid=0 next cycle, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Throughput: one outstanding operation.
- Latency: handshake in cycle 0 -> o_sq_start in cycle 1 -> i_sq_valid in cycle ITER+2 -> o_res_valid in cycle ITER+3.
  - ITER = core iteration count; 16 for WIDTH=32, FRACT_BITS=0, giving cycle 19.
- Requester contract:
  - A requester holds valid and radicand stable until ready.
  - Deasserting valid before grant is legal; it is simply skipped.
  - A requester may re-request immediately; RR guarantees the others are served first.
- Fairness: with all requesters continuously valid, service order is strictly cyclic. Worst-case wait is N_REQ-1 operations.
- Invalid or out-of-range ptr values cannot occur: the ptr wraps via explicit compare, not power-of-two overflow.

Test Plan:
- Single request, real core WIDTH=32: req1 rad=150 -> o_sq_start pulses cycle 1; o_res_valid at cycle 19 with id=1, root=12, rem=6, err=0; o_req_ready[1] high only in cycle 0.
- All four valid simultaneously, rads 0/1/144/0xFFFFFFFF, i_res_ready=1 -> results in order id 0,1,2,3 with roots 0,1,12,65535 and rems 0,0,0,131070; ptr ends at 0.
- Backpressure: i_res_ready=0 for 10 cycles in RESP -> id/root/rem stable; no o_req_ready asserted while req2 is waiting; req2 is granted the cycle after the handshake returns to IDLE.
- Fairness: req0 continuously re-requesting, req3 valid -> req3 is served immediately after req0's first result, not a second req0 result.
- Timeout: stub core never asserts i_sq_valid -> o_res_valid with err=1, root=rem=0 after TIMEOUT cycles in WAIT; o_timeout_cnt=1; next request proceeds normally.
- Reset mid-WAIT with core busy -> all outputs 0 immediately; a pending request is not granted until i_sq_busy falls, then completes correctly.
